// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with illegal-opcode and bus-timeout traps.
// Optional MULTICYCLE_CTRL_PERF_EN adds cycle_count / instret_count performance counters.
module multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ir2,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic [2:0]  sext_select,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        mem_re,
    output logic        mem_we,
    output logic        alu_src_imm,
    output logic        illegal,
    output logic        bus_err
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instret_count
`endif
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Timeout fires on the last permitted waiting cycle, so exactly MEM_WAIT_MAX cycles are tolerated.
    localparam logic [7:0] WAIT_LAST = (MEM_WAIT_MAX == 0) ? 8'd0 : 8'(MEM_WAIT_MAX - 1);

    state_t      state, state_nx;
    logic [6:0]  opc, opc_nx;
    logic [2:0]  sext_nx;
    logic        illegal_nx, bus_err_nx;
    logic [7:0]  wait_cnt, wait_cnt_nx;
    logic        waiting, timeout;
    logic        ir2_unused;

    assign ir2_unused = ^ir2[31:7];
    assign timeout    = (MEM_WAIT_MAX != 0) && (wait_cnt == WAIT_LAST);

    always_comb begin
        state_nx    = state;
        opc_nx      = opc;
        sext_nx     = sext_select;
        illegal_nx  = illegal;
        bus_err_nx  = bus_err;
        waiting     = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = 2'd0;
        reg_we      = 1'b0;
        wb_sel      = 2'd0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        alu_src_imm = 1'b0;
        case (state)
            FETCH: begin
                mem_re = 1'b1;
                if (mem_ready) begin
                    ir_we    = 1'b1;
                    state_nx = DECODE;
                end else if (timeout) begin
                    bus_err_nx = 1'b1;
                    state_nx   = TRAP;
                end else begin
                    waiting = 1'b1;
                end
            end
            DECODE: begin
                opc_nx   = ir2[6:0];
                state_nx = EXEC;
                case (ir2[6:0])
                    OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_OP: sext_nx = 3'd0;
                    OPC_BRANCH:                            sext_nx = 3'd1;
                    OPC_LUI, OPC_AUIPC:                    sext_nx = 3'd2;
                    OPC_STORE:                             sext_nx = 3'd3;
                    OPC_JAL:                               sext_nx = 3'd4;
                    default: begin
                        illegal_nx = 1'b1;
                        state_nx   = TRAP;
                    end
                endcase
            end
            EXEC: begin
                alu_src_imm = !(opc == OPC_OP || opc == OPC_BRANCH);
                case (opc)
                    OPC_BRANCH: begin
                        pc_we    = 1'b1;
                        pc_sel   = branch_taken ? 2'd1 : 2'd0;
                        state_nx = FETCH;
                    end
                    OPC_LOAD, OPC_STORE: state_nx = MEM;
                    default:             state_nx = WB;
                endcase
            end
            MEM: begin
                if (opc == OPC_STORE) begin
                    mem_we = 1'b1;
                end else begin
                    mem_re = 1'b1;
                end
                if (mem_ready) begin
                    if (opc == OPC_STORE) begin
                        pc_we    = 1'b1;
                        state_nx = FETCH;
                    end else begin
                        state_nx = WB;
                    end
                end else if (timeout) begin
                    mem_we     = 1'b0;
                    bus_err_nx = 1'b1;
                    state_nx   = TRAP;
                end else begin
                    waiting = 1'b1;
                end
            end
            WB: begin
                reg_we   = 1'b1;
                pc_we    = 1'b1;
                state_nx = FETCH;
                case (opc)
                    OPC_JAL:  begin pc_sel = 2'd2; wb_sel = 2'd2; end
                    OPC_JALR: begin pc_sel = 2'd3; wb_sel = 2'd2; end
                    OPC_LOAD: wb_sel = 2'd1;
                    OPC_LUI:  wb_sel = 2'd3;
                    default:  wb_sel = 2'd0;
                endcase
            end
            TRAP:    state_nx = TRAP;
            default: state_nx = FETCH;
        endcase

        wait_cnt_nx = (state_nx != state) ? 8'd0 : (waiting ? wait_cnt + 8'd1 : wait_cnt);

        // Reset drops any outstanding request: nothing fires in the reset cycle.
        if (rst) begin
            ir_we       = 1'b0;
            pc_we       = 1'b0;
            pc_sel      = 2'd0;
            reg_we      = 1'b0;
            wb_sel      = 2'd0;
            mem_re      = 1'b0;
            mem_we      = 1'b0;
            alu_src_imm = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            opc         <= 7'd0;
            sext_select <= 3'd0;
            illegal     <= 1'b0;
            bus_err     <= 1'b0;
            wait_cnt    <= 8'd0;
        end else begin
            state       <= state_nx;
            opc         <= opc_nx;
            sext_select <= sext_nx;
            illegal     <= illegal_nx;
            bus_err     <= bus_err_nx;
            wait_cnt    <= wait_cnt_nx;
        end
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count   <= 32'd0;
            instret_count <= 32'd0;
        end else begin
            if (state != TRAP) cycle_count <= cycle_count + 32'd1;
            if (pc_we)         instret_count <= instret_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected output traces built from instruction classes.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ir2 = 32'd0;
    logic        mem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic [2:0]  sext_select;
    logic        ir_we, pc_we, reg_we, mem_re, mem_we, alu_src_imm, illegal, bus_err;
    logic [1:0]  pc_sel, wb_sel;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_count, instret_count;
`endif

    multicycle_ctrl #(.MEM_WAIT_MAX(4)) dut (
        .clk(clk), .rst(rst), .ir2(ir2), .mem_ready(mem_ready), .branch_taken(branch_taken),
        .sext_select(sext_select), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .reg_we(reg_we), .wb_sel(wb_sel), .mem_re(mem_re), .mem_we(mem_we),
        .alu_src_imm(alu_src_imm), .illegal(illegal), .bus_err(bus_err)
`ifdef MULTICYCLE_CTRL_PERF_EN
        , .cycle_count(cycle_count), .instret_count(instret_count)
`endif
    );

    always #5 clk = ~clk;

    logic [11:0] obs;
    assign obs = {ir_we, pc_we, pc_sel, reg_we, wb_sel, mem_re, mem_we, alu_src_imm, illegal, bus_err};

    typedef struct {
        logic        r;
        logic        rdy;
        logic        bt;
        logic [31:0] ir;
        logic [11:0] exp;
        logic        chk_sx;
        logic [2:0]  sx;
        string       tag;
    } step_t;

    step_t q[$];
    int    tests = 0;
    int    fails = 0;
    logic  post_rst = 1'b0;

    function automatic logic [11:0] mk(input logic iw, input logic pw, input logic [1:0] ps,
                                       input logic rw, input logic [1:0] ws, input logic mr,
                                       input logic mw, input logic al, input logic il, input logic be);
        return {iw, pw, ps, rw, ws, mr, mw, al, il, be};
    endfunction

    task automatic push(input logic r, input logic rdy, input logic bt, input logic [31:0] ir,
                        input logic [11:0] exp, input logic chk, input logic [2:0] sx, input string tag);
        step_t s;
        s.r = r; s.rdy = rdy; s.bt = bt; s.ir = ir; s.exp = exp;
        s.chk_sx = chk; s.sx = sx; s.tag = tag;
        q.push_back(s);
    endtask

    task automatic add_rst(input int n, input logic il, input logic be);
        for (int i = 0; i < n; i++)
            push(1'b1, 1'($urandom), 1'($urandom), $urandom, mk(0,0,0,0,0,0,0,0,il,be), 1'b0, 3'd0, "reset");
        post_rst = 1'b1;
    endtask

    // Reference: expected per-cycle behaviour of one instruction, derived from its class.
    task automatic add_instr(input logic [31:0] ins, input int fw, input int mw, input logic bt, input string tag);
        logic [6:0] op;
        logic ld, st, br, rr, jal, jalr, lui, aui, legal, cs, al;
        logic [2:0] sx;
        logic [1:0] ps, ws;
        op    = ins[6:0];
        ld    = (op == 7'h03); st  = (op == 7'h23); br   = (op == 7'h63);
        rr    = (op == 7'h33); jal = (op == 7'h6F); jalr = (op == 7'h67);
        lui   = (op == 7'h37); aui = (op == 7'h17);
        legal = ld | st | br | rr | jal | jalr | lui | aui | (op == 7'h13);
        sx    = br ? 3'd1 : (lui | aui) ? 3'd2 : st ? 3'd3 : jal ? 3'd4 : 3'd0;
        cs    = post_rst;
        post_rst = 1'b0;
        for (int i = 0; i < fw; i++)
            push(1'b0, 1'b0, 1'($urandom), $urandom, mk(0,0,0,0,0,1,0,0,0,0), cs, 3'd0, {tag, ".fetch_wait"});
        push(1'b0, 1'b1, 1'($urandom), $urandom, mk(1,0,0,0,0,1,0,0,0,0), cs, 3'd0, {tag, ".fetch"});
        push(1'b0, 1'($urandom), 1'($urandom), ins, mk(0,0,0,0,0,0,0,0,0,0), cs, 3'd0, {tag, ".decode"});
        if (!legal) begin
            for (int i = 0; i < 20; i++)
                push(1'b0, 1'($urandom), 1'($urandom), ins, mk(0,0,0,0,0,0,0,0,1,0), 1'b0, 3'd0, {tag, ".trap"});
            return;
        end
        al = !(rr | br);
        push(1'b0, 1'($urandom), bt, ins, mk(0, br, {1'b0, br & bt}, 0, 0, 0, 0, al, 0, 0), 1'b1, sx, {tag, ".exec"});
        if (ld | st) begin
            for (int i = 0; i < mw; i++)
                push(1'b0, 1'b0, 1'($urandom), ins, mk(0,0,0,0,0,ld,st,0,0,0), 1'b1, sx, {tag, ".mem_wait"});
            push(1'b0, 1'b1, 1'($urandom), ins, mk(0,st,0,0,0,ld,st,0,0,0), 1'b1, sx, {tag, ".mem"});
        end
        if (!(br | st)) begin
            ps = jal ? 2'd2 : jalr ? 2'd3 : 2'd0;
            ws = ld ? 2'd1 : (jal | jalr) ? 2'd2 : lui ? 2'd3 : 2'd0;
            push(1'b0, 1'($urandom), 1'($urandom), ins, mk(0,1,ps,1,ws,0,0,0,0,0), 1'b1, sx, {tag, ".wb"});
        end
    endtask

    task automatic run_q();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(negedge clk);
            rst = s.r; mem_ready = s.rdy; branch_taken = s.bt; ir2 = s.ir;
            #1;
            tests++;
            assert (obs === s.exp) else begin
                fails++;
                $error("FAIL %s outputs got=%b want=%b (ir_we,pc_we,pc_sel,reg_we,wb_sel,mem_re,mem_we,alu_imm,ill,berr)",
                       s.tag, obs, s.exp);
            end
            if (s.chk_sx) begin
                tests++;
                assert (sext_select === s.sx) else begin
                    fails++;
                    $error("FAIL %s sext_select got=%0d want=%0d", s.tag, sext_select, s.sx);
                end
            end
        end
    endtask

    initial begin
        logic [6:0] pool [9];
        logic [31:0] ins;
        pool = '{7'h13, 7'h03, 7'h67, 7'h63, 7'h37, 7'h17, 7'h23, 7'h6F, 7'h33};

        add_rst(2, 1'b0, 1'b0);
        add_instr(32'h00500093, 0, 0, 1'b0, "addi");
        add_instr(32'h0000A103, 0, 3, 1'b0, "lw");
        add_instr(32'h0020A223, 1, 2, 1'b0, "sw");
        add_instr(32'h00000463, 0, 0, 1'b1, "beq_taken");
        add_instr(32'h00000463, 2, 0, 1'b0, "beq_not");
        add_instr(32'h010000EF, 0, 0, 1'b0, "jal");
        add_instr(32'h123450B7, 0, 0, 1'b0, "lui");
        add_instr(32'h000080E7, 1, 0, 1'b0, "jalr");
        add_instr(32'h002081B3, 0, 0, 1'b0, "op");
        add_instr(32'h00001097, 3, 0, 1'b0, "auipc");
        run_q();

        for (int i = 0; i < 30; i++) begin
            ins = {$urandom, 7'd0} | 32'(pool[$urandom_range(0, 8)]);
            add_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), "rand");
        end
        run_q();

        add_instr(32'h00000000, 0, 0, 1'b0, "illegal");
        add_rst(1, 1'b1, 1'b0);
        add_instr(32'h00500093, 0, 0, 1'b0, "after_trap");
        run_q();

        // Fetch never completes: exactly four waiting cycles, then bus-error trap.
        add_rst(1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            push(1'b0, 1'b0, 1'b0, $urandom, mk(0,0,0,0,0,1,0,0,0,0), 1'b1, 3'd0, "timeout.fetch");
        for (int i = 0; i < 6; i++)
            push(1'b0, 1'($urandom), 1'b0, $urandom, mk(0,0,0,0,0,0,0,0,0,1), 1'b0, 3'd0, "timeout.trap");
        add_rst(1, 1'b0, 1'b1);
        post_rst = 1'b0;

        // Store interrupted by reset while waiting in MEM.
        push(1'b0, 1'b1, 1'b0, $urandom, mk(1,0,0,0,0,1,0,0,0,0), 1'b1, 3'd0, "rstmem.fetch");
        push(1'b0, 1'b0, 1'b0, 32'h0020A223, mk(0,0,0,0,0,0,0,0,0,0), 1'b0, 3'd0, "rstmem.decode");
        push(1'b0, 1'b0, 1'b0, 32'h0020A223, mk(0,0,0,0,0,0,0,1,0,0), 1'b1, 3'd3, "rstmem.exec");
        push(1'b0, 1'b0, 1'b0, 32'h0020A223, mk(0,0,0,0,0,0,1,0,0,0), 1'b1, 3'd3, "rstmem.mem");
        add_rst(1, 1'b0, 1'b0);
        add_instr(32'h00500093, 1, 0, 1'b0, "after_rstmem");
        run_q();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
